// File: rtl/controle_pkg.sv
// ============================================================================
// controle_pkg : shared encodings for the multicycle RV64I control unit
// Revision     : 1.0
// ============================================================================
`default_nettype none

package controle_pkg;

    typedef enum logic [2:0] {
        BUSCA      = 3'd0,
        DECODIFICA = 3'd1,
        EXECUTA    = 3'd2,
        MEMORIA    = 3'd3,
        ESCRITA    = 3'd4,
        TRAVADO    = 3'd5
    } estado_t;

    typedef enum logic [2:0] {
        CL_ALU      = 3'd0,
        CL_ALUI     = 3'd1,
        CL_LD       = 3'd2,
        CL_SD       = 3'd3,
        CL_BR       = 3'd4,
        CL_INVALIDA = 3'd5
    } classe_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_D    = 3'b011;

    // Unsigned less-than is derived from "not greater and not equal".
    function automatic logic desvio_tomado(input logic [2:0] f3,
                                           input logic igual,
                                           input logic menor,
                                           input logic maior_u);
        logic r;
        case (f3)
            F3_BEQ:  r = igual;
            F3_BNE:  r = !igual;
            F3_BLT:  r = menor;
            F3_BGE:  r = !menor;
            F3_BLTU: r = !maior_u && !igual;
            F3_BGEU: r = maior_u || igual;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decodificador_classe.sv
// ============================================================================
// decodificador_classe : combinational opcode/funct3 -> instruction class
// Revision             : 1.0
// ============================================================================
`default_nettype none

module decodificador_classe
    import controle_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output classe_t    classe
);

    always_comb begin
        classe = CL_INVALIDA;
        case (opcode)
            OP_R:      if (funct3 == F3_ADD) classe = CL_ALU;
            OP_I:      if (funct3 == F3_ADD) classe = CL_ALUI;
            OP_LOAD:   if (funct3 == F3_D)   classe = CL_LD;
            OP_STORE:  if (funct3 == F3_D)   classe = CL_SD;
            OP_BRANCH: if (funct3 != 3'b010 && funct3 != 3'b011) classe = CL_BR;
            default:   classe = CL_INVALIDA;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/unidade_controle_multiciclo.sv
// ============================================================================
// unidade_controle_multiciclo : multicycle control FSM for the RV64I datapath
// Option macro : CONTROLE_TRAP_INVALIDA_EN (illegal instruction locks in TRAVADO)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module unidade_controle_multiciclo
    import controle_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       flag_igual,
    input  logic       flag_menor,
    input  logic       flag_maior_u,
    input  logic       mem_pronto,
    output logic       soma_ou_subtrai,
    output logic       subtraindo,
    output logic       imediato,
    output logic       ir_load,
    output logic       pc_load,
    output logic       pc_src,
    output logic       mem_re,
    output logic       mem_we,
    output logic       reg_we,
    output logic       wb_sel,
    output logic       instr_invalida,
    output logic [2:0] estado
);

    estado_t r_estado;
    estado_t w_prox;
    classe_t r_classe;
    classe_t w_classe;
    logic    w_tomado;

    decodificador_classe u_decod (
        .opcode (opcode),
        .funct3 (funct3),
        .classe (w_classe)
    );

    assign w_tomado = desvio_tomado(funct3, flag_igual, flag_menor, flag_maior_u);
    assign estado   = r_estado;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= BUSCA;
            r_classe <= CL_INVALIDA;
        end else begin
            r_estado <= w_prox;
            if (r_estado == DECODIFICA) r_classe <= w_classe;
        end
    end

    always_comb begin
        w_prox          = r_estado;
        soma_ou_subtrai = 1'b0;
        subtraindo      = 1'b0;
        imediato        = 1'b0;
        ir_load         = 1'b0;
        pc_load         = 1'b0;
        pc_src          = 1'b0;
        mem_re          = 1'b0;
        mem_we          = 1'b0;
        reg_we          = 1'b0;
        wb_sel          = 1'b0;
        instr_invalida  = 1'b0;

        // ULA controls stay stable from EXECUTA until the instruction retires.
        if (r_estado == EXECUTA || r_estado == MEMORIA || r_estado == ESCRITA) begin
            case (r_classe)
                CL_ALU: begin
                    soma_ou_subtrai = 1'b1;
                    subtraindo      = funct7_5;
                end
                CL_ALUI, CL_LD, CL_SD: begin
                    soma_ou_subtrai = 1'b1;
                    imediato        = 1'b1;
                end
                default: ;
            endcase
        end

        case (r_estado)
            BUSCA: begin
                mem_re = 1'b1;
                if (mem_pronto) begin
                    ir_load = 1'b1;
                    pc_load = 1'b1;
                    w_prox  = DECODIFICA;
                end
            end
            DECODIFICA: begin
                if (w_classe == CL_INVALIDA) begin
`ifdef CONTROLE_TRAP_INVALIDA_EN
                    w_prox = TRAVADO;
`else
                    instr_invalida = 1'b1;
                    w_prox         = BUSCA;
`endif
                end else begin
                    w_prox = EXECUTA;
                end
            end
            EXECUTA: begin
                case (r_classe)
                    CL_ALU, CL_ALUI: w_prox = ESCRITA;
                    CL_LD, CL_SD:    w_prox = MEMORIA;
                    CL_BR: begin
                        pc_load = w_tomado;
                        pc_src  = w_tomado;
                        w_prox  = BUSCA;
                    end
                    default:         w_prox = BUSCA;
                endcase
            end
            MEMORIA: begin
                if (r_classe == CL_LD) mem_re = 1'b1;
                else                   mem_we = 1'b1;
                if (mem_pronto) w_prox = (r_classe == CL_LD) ? ESCRITA : BUSCA;
            end
            ESCRITA: begin
                reg_we = 1'b1;
                wb_sel = (r_classe == CL_LD);
                w_prox = BUSCA;
            end
            TRAVADO: begin
`ifdef CONTROLE_TRAP_INVALIDA_EN
                instr_invalida = 1'b1;
`else
                w_prox = BUSCA;
`endif
            end
            default: w_prox = BUSCA;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_unidade_controle_multiciclo.sv
// ============================================================================
// tb_unidade_controle_multiciclo : directed self-checking bench for the control FSM
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_unidade_controle_multiciclo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       flag_igual, flag_menor, flag_maior_u;
    logic       mem_pronto;
    logic       soma_ou_subtrai, subtraindo, imediato;
    logic       ir_load, pc_load, pc_src, mem_re, mem_we, reg_we, wb_sel;
    logic       instr_invalida;
    logic [2:0] estado;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    unidade_controle_multiciclo dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .opcode          (opcode),
        .funct3          (funct3),
        .funct7_5        (funct7_5),
        .flag_igual      (flag_igual),
        .flag_menor      (flag_menor),
        .flag_maior_u    (flag_maior_u),
        .mem_pronto      (mem_pronto),
        .soma_ou_subtrai (soma_ou_subtrai),
        .subtraindo      (subtraindo),
        .imediato        (imediato),
        .ir_load         (ir_load),
        .pc_load         (pc_load),
        .pc_src          (pc_src),
        .mem_re          (mem_re),
        .mem_we          (mem_we),
        .reg_we          (reg_we),
        .wb_sel          (wb_sel),
        .instr_invalida  (instr_invalida),
        .estado          (estado)
    );

    // Output bundle order: soma sub imed ir_load pc_load pc_src mem_re mem_we reg_we wb_sel inv
    localparam logic [10:0] O_FETCH = 11'b000_110_1_0_0_0_0;
    localparam logic [10:0] O_WAIT  = 11'b000_000_1_0_0_0_0;
    localparam logic [10:0] O_ZERO  = 11'b000_000_0_0_0_0_0;
    localparam logic [10:0] O_SUB   = 11'b110_000_0_0_0_0_0;
    localparam logic [10:0] O_SUBWB = 11'b110_000_0_0_1_0_0;
    localparam logic [10:0] O_IMM   = 11'b101_000_0_0_0_0_0;
    localparam logic [10:0] O_LDMEM = 11'b101_000_1_0_0_0_0;
    localparam logic [10:0] O_LDWB  = 11'b101_000_0_0_1_1_0;
    localparam logic [10:0] O_SDMEM = 11'b101_000_0_1_0_0_0;
    localparam logic [10:0] O_BRTK  = 11'b000_011_0_0_0_0_0;
    localparam logic [10:0] O_INV   = 11'b000_000_0_0_0_0_1;

    function automatic logic [13:0] observado();
        return {estado, soma_ou_subtrai, subtraindo, imediato, ir_load, pc_load,
                pc_src, mem_re, mem_we, reg_we, wb_sel, instr_invalida};
    endfunction

    task automatic chk(input string tag, input logic [2:0] est, input logic [10:0] outs);
        logic [13:0] obs;
        logic [13:0] exp_v;
        obs   = observado();
        exp_v = {est, outs};
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed estado=%0d outs=%b expected estado=%0d outs=%b",
                   tag, obs[13:11], obs[10:0], exp_v[13:11], exp_v[10:0]);
        end
    endtask

    // Check at the falling edge, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [2:0] est, input logic [10:0] outs);
        @(negedge clk);
        chk(tag, est, outs);
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
    endtask

    initial begin
        rst_n = 1'b0;
        instr(7'b0110011, 3'b000, 1'b1);
        {flag_igual, flag_menor, flag_maior_u} = 3'b000;
        mem_pronto = 1'b1;
        @(negedge clk);
        chk("reset", 3'd0, O_FETCH);
        mem_pronto = 1'b0;
        #1 chk("reset_wait", 3'd0, O_WAIT);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // sub: 4 cycles, one extra BUSCA cycle while memory not ready
        cyc("sub_busca_wait", 3'd0, O_WAIT);
        mem_pronto = 1'b1;
        cyc("sub_busca", 3'd0, O_FETCH);
        cyc("sub_decod", 3'd1, O_ZERO);
        cyc("sub_exec", 3'd2, O_SUB);
        cyc("sub_escrita", 3'd4, O_SUBWB);

        // ld with two stall cycles in MEMORIA: 7 cycles total
        instr(7'b0000011, 3'b011, 1'b0);
        cyc("ld_busca", 3'd0, O_FETCH);
        cyc("ld_decod", 3'd1, O_ZERO);
        cyc("ld_exec", 3'd2, O_IMM);
        mem_pronto = 1'b0;
        cyc("ld_mem0", 3'd3, O_LDMEM);
        cyc("ld_mem1", 3'd3, O_LDMEM);
        mem_pronto = 1'b1;
        cyc("ld_mem2", 3'd3, O_LDMEM);
        cyc("ld_escrita", 3'd4, O_LDWB);

        // bltu taken, then bltu with equal flag not taken
        instr(7'b1100011, 3'b110, 1'b0);
        cyc("bltu_busca", 3'd0, O_FETCH);
        cyc("bltu_decod", 3'd1, O_ZERO);
        cyc("bltu_exec_tk", 3'd2, O_BRTK);
        flag_igual = 1'b1;
        cyc("bltu2_busca", 3'd0, O_FETCH);
        cyc("bltu2_decod", 3'd1, O_ZERO);
        cyc("bltu2_exec_nt", 3'd2, O_ZERO);

        // bge: not taken when less, taken otherwise
        instr(7'b1100011, 3'b101, 1'b0);
        {flag_igual, flag_menor, flag_maior_u} = 3'b010;
        cyc("bge_busca", 3'd0, O_FETCH);
        cyc("bge_decod", 3'd1, O_ZERO);
        cyc("bge_exec_nt", 3'd2, O_ZERO);
        flag_menor = 1'b0;
        cyc("bge2_busca", 3'd0, O_FETCH);
        cyc("bge2_decod", 3'd1, O_ZERO);
        cyc("bge2_exec_tk", 3'd2, O_BRTK);

        // addi then sd: one-cycle mem_we, no reg_we
        instr(7'b0010011, 3'b000, 1'b1);
        cyc("addi_busca", 3'd0, O_FETCH);
        cyc("addi_decod", 3'd1, O_ZERO);
        cyc("addi_exec", 3'd2, O_IMM);
        cyc("addi_escrita", 3'd4, 11'b101_000_0_0_1_0_0);
        instr(7'b0100011, 3'b011, 1'b0);
        cyc("sd_busca", 3'd0, O_FETCH);
        cyc("sd_decod", 3'd1, O_ZERO);
        cyc("sd_exec", 3'd2, O_IMM);
        cyc("sd_mem", 3'd3, O_SDMEM);

        // sd aborted by reset in MEMORIA with memory stalled
        cyc("sd2_busca", 3'd0, O_FETCH);
        cyc("sd2_decod", 3'd1, O_ZERO);
        mem_pronto = 1'b0;
        cyc("sd2_exec", 3'd2, O_IMM);
        cyc("sd2_mem_stall", 3'd3, O_SDMEM);
        #2 rst_n = 1'b0;
        #1 chk("sd2_abort", 3'd0, O_WAIT);
        @(posedge clk);
        #1 rst_n = 1'b1;
        mem_pronto = 1'b1;
        instr(7'b0110011, 3'b000, 1'b0);
        cyc("add_busca", 3'd0, O_FETCH);
        cyc("add_decod", 3'd1, O_ZERO);
        cyc("add_exec", 3'd2, 11'b100_000_0_0_0_0_0);
        cyc("add_escrita", 3'd4, 11'b100_000_0_0_1_0_0);

        // illegal opcode
        instr(7'b1111111, 3'b000, 1'b0);
        cyc("inv_busca", 3'd0, O_FETCH);
`ifdef CONTROLE_TRAP_INVALIDA_EN
        cyc("inv_decod", 3'd1, O_ZERO);
        cyc("inv_trav0", 3'd5, O_INV);
        cyc("inv_trav1", 3'd5, O_INV);
        cyc("inv_trav2", 3'd5, O_INV);
        rst_n = 1'b0;
        #1 chk("inv_reset", 3'd0, O_FETCH);
`else
        cyc("inv_decod", 3'd1, O_INV);
        cyc("inv_retorno", 3'd0, O_FETCH);
        cyc("inv_decod2", 3'd1, O_INV);
        instr(7'b0110011, 3'b001, 1'b0);
        cyc("inv_f3_busca", 3'd0, O_FETCH);
        cyc("inv_f3_decod", 3'd1, O_INV);
        cyc("inv_f3_retorno", 3'd0, O_FETCH);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
